// File: rtl/hazard_pkg.sv
// Shared constants and types for the pipeline hazard/forwarding controller.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents:
//   FWD_REG / FWD_WB / FWD_MEM : ALU operand forwarding select encodings
//   mdu_state_t                : MDU stall sequencer state encoding
package hazard_pkg;

   // ALU operand source select driven onto the EX operand muxes
   localparam logic [1:0] FWD_REG = 2'b00;   // register file value
   localparam logic [1:0] FWD_WB  = 2'b01;   // result being written back
   localparam logic [1:0] FWD_MEM = 2'b10;   // ALU result sitting in MEM

   // MDU stall sequencer
   //   IDLE : no MDU op held in EX
   //   BUSY : MDU op held in EX, latency countdown running
   //   DONE : final cycle, op released from EX; a new op is not accepted here
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } mdu_state_t;

endpackage : hazard_pkg

// File: rtl/mdu_stall_fsm.sv
// Holds an MDU op in EX for MDU_LAT cycles (detect cycle + MDU_LAT-1 BUSY cycles).
// Latency: o_hold combinational from i_mdu_op_E in IDLE; o_mdu_busy registered.
// Backpressure: o_hold is the stall request; DONE ignores i_mdu_op_E so an op never retriggers itself.
//
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_mdu_op_E     : MDU instruction currently in EX
//   o_hold         : hold IF/ID/EX and bubble MEM this cycle
//   o_mdu_busy     : registered, high while the sequencer is in BUSY or DONE
module mdu_stall_fsm
   import hazard_pkg::*;
#(
   parameter int MDU_LAT = 4
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_mdu_op_E,
   output logic o_hold,
   output logic o_mdu_busy
);

   localparam int                CNT_W    = $clog2(MDU_LAT);
   localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(MDU_LAT - 1);
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

   mdu_state_t       state;
   logic [CNT_W-1:0] cnt;

   // Counter is loaded with MDU_LAT-1 on detect and counts one per BUSY cycle;
   // the cycle whose decrement brings it to zero is the last BUSY cycle, so BUSY
   // lasts exactly MDU_LAT-1 cycles.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         o_mdu_busy <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (i_mdu_op_E) begin
                  state      <= BUSY;
                  cnt        <= CNT_LOAD;
                  o_mdu_busy <= 1'b1;
               end
            end
            BUSY: begin
               cnt <= cnt - CNT_ONE;
               if (cnt == CNT_ONE) begin
                  state <= DONE;
               end
            end
            DONE: begin
               // Unconditional: the op that just completed is still in EX this
               // cycle and must not start another sequence.
               state      <= IDLE;
               o_mdu_busy <= 1'b0;
            end
            default: begin
               state      <= IDLE;
               cnt        <= '0;
               o_mdu_busy <= 1'b0;
            end
         endcase
      end
   end

   // The detect cycle stalls as well, so the hold request looks at the input
   // directly while IDLE.
   assign o_hold = ((state == IDLE) && i_mdu_op_E) || (state == BUSY);

endmodule : mdu_stall_fsm

// File: rtl/hazard_ctrl_unit.sv
// Hazard and forwarding controller for the 5-stage MIPS pipeline.
// Latency: forwarding/stall/flush combinational from inputs and MDU state; o_mdu_busy and stats registered.
// Backpressure: drives stall (hold) and flush (bubble) of IF/ID, ID/EX, EX/MEM; MDU hold overrides flush_E.
//
// Ports:
//   i_clk, i_rst_n                       : clock, asynchronous active-low reset
//   i_instr_rs_D/rt_D, i_instr_rs_E/rt_E : source registers in ID / EX
//   i_write_reg_E/M/W, i_reg_write_E/M/W : destination register and RegWrite per stage
//   i_mem_to_reg_E/M                     : load in EX / MEM
//   i_branch_D                           : branch/compare in ID
//   i_mdu_op_E                           : multiply/divide op in EX
//   o_forward_a/b                        : ALU operand select (FWD_REG/FWD_WB/FWD_MEM)
//   o_forward_eq_a/b                     : comparator operand taken from MEM
//   o_stall_F/D/E                        : hold PC, IF/ID, ID/EX
//   o_flush_E/M                          : bubble into ID/EX, EX/MEM
//   o_mdu_busy                           : MDU sequencer active
//   o_stall_cycles/o_flush_cycles        : saturating statistics
//
// Build option: HAZARD_CTRL_STATS_EN enables the statistics counters; when it
// is not defined the statistics ports are tied to zero and have no flops.
module hazard_ctrl_unit
   import hazard_pkg::*;
#(
   parameter int REG_ADDR_W = 5,
   parameter int MDU_LAT    = 4,
   parameter int STAT_W     = 16
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic [REG_ADDR_W-1:0] i_instr_rs_D,
   input  logic [REG_ADDR_W-1:0] i_instr_rt_D,
   input  logic [REG_ADDR_W-1:0] i_instr_rs_E,
   input  logic [REG_ADDR_W-1:0] i_instr_rt_E,
   input  logic [REG_ADDR_W-1:0] i_write_reg_E,
   input  logic [REG_ADDR_W-1:0] i_write_reg_M,
   input  logic [REG_ADDR_W-1:0] i_write_reg_W,
   input  logic                  i_reg_write_E,
   input  logic                  i_reg_write_M,
   input  logic                  i_reg_write_W,
   input  logic                  i_mem_to_reg_E,
   input  logic                  i_mem_to_reg_M,
   input  logic                  i_branch_D,
   input  logic                  i_mdu_op_E,
   output logic [1:0]            o_forward_a,
   output logic [1:0]            o_forward_b,
   output logic                  o_forward_eq_a,
   output logic                  o_forward_eq_b,
   output logic                  o_stall_F,
   output logic                  o_stall_D,
   output logic                  o_stall_E,
   output logic                  o_flush_E,
   output logic                  o_flush_M,
   output logic                  o_mdu_busy,
   output logic [STAT_W-1:0]     o_stall_cycles,
   output logic [STAT_W-1:0]     o_flush_cycles
);

   if (MDU_LAT < 2) begin : g_bad_mdu_lat
      $error("hazard_ctrl_unit: MDU_LAT must be at least 2");
   end

   // ---------------------------------------------------------------------
   // Producer qualification: r0 is never a real destination
   // ---------------------------------------------------------------------
   logic wr_E_vld;
   logic wr_M_vld;
   logic wr_W_vld;
   logic load_E_vld;
   logic load_M_vld;

   assign wr_E_vld   = i_reg_write_E && (i_write_reg_E != '0);
   assign wr_M_vld   = i_reg_write_M && (i_write_reg_M != '0);
   assign wr_W_vld   = i_reg_write_W && (i_write_reg_W != '0);
   assign load_E_vld = i_mem_to_reg_E && wr_E_vld;
   // Load result in MEM is only available after the memory read, so it cannot
   // feed the ID comparator; qualified by mem_to_reg rather than reg_write.
   assign load_M_vld = i_mem_to_reg_M && (i_write_reg_M != '0);

   // ---------------------------------------------------------------------
   // ALU operand forwarding: the younger producer (MEM) has priority
   // ---------------------------------------------------------------------
   always_comb begin
      o_forward_a = FWD_REG;
      if (wr_M_vld && (i_write_reg_M == i_instr_rs_E)) begin
         o_forward_a = FWD_MEM;
      end else if (wr_W_vld && (i_write_reg_W == i_instr_rs_E)) begin
         o_forward_a = FWD_WB;
      end
   end

   always_comb begin
      o_forward_b = FWD_REG;
      if (wr_M_vld && (i_write_reg_M == i_instr_rt_E)) begin
         o_forward_b = FWD_MEM;
      end else if (wr_W_vld && (i_write_reg_W == i_instr_rt_E)) begin
         o_forward_b = FWD_WB;
      end
   end

   // ---------------------------------------------------------------------
   // Branch comparator forwarding from MEM; each operand independent
   // ---------------------------------------------------------------------
   assign o_forward_eq_a = wr_M_vld && (i_write_reg_M == i_instr_rs_D);
   assign o_forward_eq_b = wr_M_vld && (i_write_reg_M == i_instr_rt_D);

   // ---------------------------------------------------------------------
   // ID-stage hazards
   // ---------------------------------------------------------------------
   logic e_hits_d;
   logic m_load_hits_d;
   logic load_use_haz;
   logic branch_haz;
   logic id_haz;

   assign e_hits_d      = (i_write_reg_E == i_instr_rs_D) || (i_write_reg_E == i_instr_rt_D);
   assign m_load_hits_d = (i_write_reg_M == i_instr_rs_D) || (i_write_reg_M == i_instr_rt_D);

   assign load_use_haz = load_E_vld && e_hits_d;
   // The comparator resolves in ID, so any ALU result still in EX, or a load
   // still in MEM, is not yet forwardable to it.
   assign branch_haz   = i_branch_D && ((wr_E_vld && e_hits_d) || (load_M_vld && m_load_hits_d));
   assign id_haz       = load_use_haz || branch_haz;

   // ---------------------------------------------------------------------
   // MDU sequencing
   // ---------------------------------------------------------------------
   logic mdu_hold;

   mdu_stall_fsm #(
      .MDU_LAT (MDU_LAT)
   ) u_mdu_stall_fsm (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_mdu_op_E (i_mdu_op_E),
      .o_hold     (mdu_hold),
      .o_mdu_busy (o_mdu_busy)
   );

   // ---------------------------------------------------------------------
   // Stall / flush
   // ---------------------------------------------------------------------
   assign o_stall_F = id_haz || mdu_hold;
   assign o_stall_D = id_haz || mdu_hold;
   assign o_stall_E = mdu_hold;
   // While EX is held the instruction in ID stays put, so no bubble may be
   // inserted behind it; the bubble goes into MEM instead.
   assign o_flush_E = id_haz && !mdu_hold;
   assign o_flush_M = mdu_hold;

   // ---------------------------------------------------------------------
   // Statistics
   // ---------------------------------------------------------------------
`ifdef HAZARD_CTRL_STATS_EN
   localparam logic [STAT_W-1:0] STAT_ONE = STAT_W'(1);

   logic [STAT_W-1:0] stall_cnt;
   logic [STAT_W-1:0] flush_cnt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (o_stall_D && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + STAT_ONE;
         end
         if ((o_flush_E || o_flush_M) && (flush_cnt != '1)) begin
            flush_cnt <= flush_cnt + STAT_ONE;
         end
      end
   end

   assign o_stall_cycles = stall_cnt;
   assign o_flush_cycles = flush_cnt;
`else
   assign o_stall_cycles = '0;
   assign o_flush_cycles = '0;
`endif

endmodule : hazard_ctrl_unit

// File: tb/tb_hazard_ctrl_unit.sv
// Self-checking bench for hazard_ctrl_unit (MDU_LAT=4, STAT_W=2).
// Latency: n/a.
// Backpressure: n/a.
module tb_hazard_ctrl_unit;

   localparam int AW  = 5;
   localparam int LAT = 4;
   localparam int SW  = 2;
   localparam int SAT = (1 << SW) - 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n;
   logic [AW-1:0] rs_D, rt_D, rs_E, rt_E, wr_E, wr_M, wr_W;
   logic          rw_E, rw_M, rw_W, m2r_E, m2r_M, br_D, mdu_op;
   logic [1:0]    fa, fb;
   logic          eqa, eqb, sF, sD, sE, fE, fM, busy;
   logic [SW-1:0] scyc, fcyc;

   hazard_ctrl_unit #(.REG_ADDR_W(AW), .MDU_LAT(LAT), .STAT_W(SW)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_instr_rs_D(rs_D), .i_instr_rt_D(rt_D),
      .i_instr_rs_E(rs_E), .i_instr_rt_E(rt_E),
      .i_write_reg_E(wr_E), .i_write_reg_M(wr_M), .i_write_reg_W(wr_W),
      .i_reg_write_E(rw_E), .i_reg_write_M(rw_M), .i_reg_write_W(rw_W),
      .i_mem_to_reg_E(m2r_E), .i_mem_to_reg_M(m2r_M),
      .i_branch_D(br_D), .i_mdu_op_E(mdu_op),
      .o_forward_a(fa), .o_forward_b(fb),
      .o_forward_eq_a(eqa), .o_forward_eq_b(eqb),
      .o_stall_F(sF), .o_stall_D(sD), .o_stall_E(sE),
      .o_flush_E(fE), .o_flush_M(fM), .o_mdu_busy(busy),
      .o_stall_cycles(scyc), .o_flush_cycles(fcyc)
   );

   int vecs = 0;
   int errs = 0;

   // ---------------- reference model ----------------
   // The MDU is modelled as a timeline: an op accepted at cycle t0 holds EX for
   // cycles t0..t0+LAT-1, is released at t0+LAT, and busy reads high from
   // t0+1 to t0+LAT. Stats count the cycles the model says are stalled/flushed.
   int cyc    = 0;
   int mstart = -1;
   int m_sc   = 0;
   int m_fc   = 0;
   logic       start_now;
   logic [1:0] e_fa, e_fb;
   logic       e_eqa, e_eqb, e_sF, e_sD, e_sE, e_fE, e_fM, e_busy;
   int         e_sc, e_fc;

   function automatic logic [1:0] fwd_sel(input logic [AW-1:0] src);
      if (rw_M && wr_M != 0 && wr_M == src) return 2'b10;
      if (rw_W && wr_W != 0 && wr_W == src) return 2'b01;
      return 2'b00;
   endfunction

   task automatic model_eval();
      logic active, hold, lu, brh, dep_E, dep_M;
      active    = (mstart >= 0) && (cyc <= mstart + LAT);
      hold      = active ? (cyc < mstart + LAT) : mdu_op;
      start_now = !active && mdu_op;
      e_busy    = active && (cyc > mstart);
      e_fa  = fwd_sel(rs_E);
      e_fb  = fwd_sel(rt_E);
      e_eqa = rw_M && wr_M != 0 && wr_M == rs_D;
      e_eqb = rw_M && wr_M != 0 && wr_M == rt_D;
      dep_E = wr_E != 0 && (wr_E == rs_D || wr_E == rt_D);
      dep_M = wr_M != 0 && (wr_M == rs_D || wr_M == rt_D);
      lu    = m2r_E && rw_E && dep_E;
      brh   = br_D && ((rw_E && dep_E) || (m2r_M && dep_M));
      e_sF  = lu || brh || hold;
      e_sD  = e_sF;
      e_sE  = hold;
      e_fE  = (lu || brh) && !hold;
      e_fM  = hold;
`ifdef HAZARD_CTRL_STATS_EN
      e_sc = m_sc;
      e_fc = m_fc;
`else
      e_sc = 0;
      e_fc = 0;
`endif
   endtask

   task automatic model_commit();
      if (start_now) mstart = cyc;
      if (e_sD && m_sc < SAT) m_sc++;
      if ((e_fE || e_fM) && m_fc < SAT) m_fc++;
      cyc++;
   endtask

   task automatic model_reset();
      mstart = -1;
      m_sc   = 0;
      m_fc   = 0;
   endtask

   task automatic clear_inputs();
      rs_D = 0; rt_D = 0; rs_E = 0; rt_E = 0; wr_E = 0; wr_M = 0; wr_W = 0;
      rw_E = 0; rw_M = 0; rw_W = 0; m2r_E = 0; m2r_M = 0; br_D = 0; mdu_op = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      clear_inputs();
      rst_n = 1'b0;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b1;
      clear_inputs();
      @(negedge clk);
      rst_n = 1'b0;
      model_reset();
      #1;
      vecs++;
      if ({busy, sF, sD, sE, fE, fM} !== 6'b0) begin
         errs++;
         $display("FAIL reset_ctrl: got %b want 000000", {busy, sF, sD, sE, fE, fM});
      end
      vecs++;
      if ({scyc, fcyc} !== '0 || {fa, fb} !== 4'b0) begin
         errs++;
         $display("FAIL reset_stats_fwd: got %h/%h fwd %b want 0", scyc, fcyc, {fa, fb});
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_forwarding();
      logic [1:0] want [3] = '{2'b10, 2'b01, 2'b00};
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         clear_inputs();
         rs_E = (k == 2) ? 5'd0 : 5'd3;
         rt_E = 5'd9;
         wr_M = 5'd3; wr_W = 5'd3;
         rw_M = (k == 0); rw_W = 1'b1;
         #1; model_eval();
         vecs++;
         if (fa !== want[k] || fa !== e_fa || fb !== e_fb) begin
            errs++;
            $display("FAIL fwd_a[%0d]: got a=%b b=%b want a=%b b=%b", k, fa, fb, want[k], e_fb);
         end
         model_commit();
      end
   endtask

   task automatic test_branch_fwd();
      logic [AW-1:0] wm [3] = '{5'd4, 5'd5, 5'd4};
      logic [AW-1:0] rt [3] = '{5'd5, 5'd5, 5'd4};
      logic [1:0]    wnt[3] = '{2'b10, 2'b01, 2'b11};
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         clear_inputs();
         br_D = 1'b1; rs_D = 5'd4; rt_D = rt[k];
         wr_M = wm[k]; rw_M = 1'b1;
         #1; model_eval();
         vecs++;
         if ({eqa, eqb} !== wnt[k] || {eqa, eqb} !== {e_eqa, e_eqb} || sD !== 1'b0) begin
            errs++;
            $display("FAIL branch_eq[%0d]: got eq=%b stall=%b want eq=%b stall=0", k, {eqa, eqb}, sD, wnt[k]);
         end
         model_commit();
      end
      // ALU result still in EX feeding the comparator stalls the branch
      @(negedge clk);
      clear_inputs();
      br_D = 1'b1; rs_D = 5'd6; wr_E = 5'd6; rw_E = 1'b1;
      #1; model_eval();
      vecs++;
      if ({sF, sD, fE} !== 3'b111 || {sF, sD, fE} !== {e_sF, e_sD, e_fE}) begin
         errs++;
         $display("FAIL branch_haz: got %b want 111", {sF, sD, fE});
      end
      model_commit();
   endtask

   task automatic test_load_use();
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         clear_inputs();
         if (k < 2) begin
            m2r_E = 1'b1; rw_E = 1'b1; rt_D = 5'd7;
            wr_E = (k == 0) ? 5'd7 : 5'd0;
         end
         #1; model_eval();
         vecs++;
         if ({sF, sD, fE, sE} !== {(k == 0), (k == 0), (k == 0), 1'b0}
             || {sF, sD, fE} !== {e_sF, e_sD, e_fE}) begin
            errs++;
            $display("FAIL load_use[%0d]: got sF/sD/fE/sE=%b", k, {sF, sD, fE, sE});
         end
         model_commit();
      end
   endtask

   task automatic test_mdu();
      do_reset();
      // op held high for LAT+2 cycles: LAT stall, one DONE, then a fresh start
      for (int k = 0; k < LAT + 2; k++) begin
         @(negedge clk);
         clear_inputs();
         mdu_op = 1'b1;
         if (k == 1 || k == LAT) begin
            m2r_E = 1'b1; rw_E = 1'b1; wr_E = 5'd7; rs_D = 5'd7;
         end
         #1; model_eval();
         vecs++;
         if (sE !== (k != LAT) || fM !== (k != LAT) || busy !== (k >= 1 && k <= LAT)
             || {sE, fM, busy, fE, sD} !== {e_sE, e_fM, e_busy, e_fE, e_sD}) begin
            errs++;
            $display("FAIL mdu_seq[%0d]: got sE=%b fM=%b busy=%b fE=%b sD=%b", k, sE, fM, busy, fE, sD);
         end
         if (k == 1 || k == LAT) begin
            vecs++;
            if (fE !== (k == LAT) || sD !== 1'b1) begin
               errs++;
               $display("FAIL mdu_flush_override[%0d]: got fE=%b sD=%b", k, fE, sD);
            end
         end
         model_commit();
      end
      // drain the restarted sequence
      for (int k = 0; k < LAT + 1; k++) begin
         @(negedge clk);
         clear_inputs();
         #1; model_eval();
         vecs++;
         if ({sE, busy} !== {e_sE, e_busy}) begin
            errs++;
            $display("FAIL mdu_drain[%0d]: got sE=%b busy=%b want %b %b", k, sE, busy, e_sE, e_busy);
         end
         model_commit();
      end
   endtask

   task automatic test_reset_mid_busy();
      int n_stall;
      do_reset();
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         mdu_op = (k == 0);
         #1; model_eval(); model_commit();
      end
      @(negedge clk);
      clear_inputs();
      rst_n = 1'b0;
      model_reset();
      #1;
      vecs++;
      if ({busy, sE, sD, fM} !== 4'b0) begin
         errs++;
         $display("FAIL reset_mid_busy: got busy/sE/sD/fM=%b want 0000", {busy, sE, sD, fM});
      end
      @(negedge clk);
      rst_n = 1'b1;
      n_stall = 0;
      for (int k = 0; k < LAT + 3; k++) begin
         @(negedge clk);
         mdu_op = (k == 0);
         #1; model_eval();
         if (sE) n_stall++;
         model_commit();
      end
      vecs++;
      if (n_stall !== LAT) begin
         errs++;
         $display("FAIL stall_after_reset: got %0d stall_E cycles want %0d", n_stall, LAT);
      end
   endtask

   task automatic test_stats();
      int want;
      do_reset();
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         clear_inputs();
         m2r_E = 1'b1; rw_E = 1'b1; wr_E = 5'd2; rt_D = 5'd2;
         #1; model_eval(); model_commit();
      end
      @(negedge clk);
      clear_inputs();
      #1; model_eval();
`ifdef HAZARD_CTRL_STATS_EN
      want = SAT;
`else
      want = 0;
`endif
      vecs++;
      if (int'(scyc) !== want || int'(fcyc) !== want || int'(scyc) !== e_sc) begin
         errs++;
         $display("FAIL stats_sat: got stall=%0d flush=%0d want %0d", scyc, fcyc, want);
      end
      model_commit();
   endtask

   task automatic test_random();
      do_reset();
      for (int k = 0; k < 600; k++) begin
         @(negedge clk);
         rs_D = AW'($urandom_range(0, 7)); rt_D = AW'($urandom_range(0, 7));
         rs_E = AW'($urandom_range(0, 7)); rt_E = AW'($urandom_range(0, 7));
         wr_E = AW'($urandom_range(0, 7)); wr_M = AW'($urandom_range(0, 7));
         wr_W = AW'($urandom_range(0, 7));
         rw_E = 1'($urandom); rw_M = 1'($urandom); rw_W = 1'($urandom);
         m2r_E = 1'($urandom); m2r_M = 1'($urandom); br_D = 1'($urandom);
         mdu_op = ($urandom_range(0, 5) == 0);
         #1; model_eval();
         vecs++;
         if ({fa, fb, eqa, eqb, sF, sD, sE, fE, fM, busy, scyc, fcyc}
             !== {e_fa, e_fb, e_eqa, e_eqb, e_sF, e_sD, e_sE, e_fE, e_fM, e_busy, SW'(e_sc), SW'(e_fc)}) begin
            errs++;
            $display("FAIL random[%0d]: got %b want %b", k,
                     {fa, fb, eqa, eqb, sF, sD, sE, fE, fM, busy, scyc, fcyc},
                     {e_fa, e_fb, e_eqa, e_eqb, e_sF, e_sD, e_sE, e_fE, e_fM, e_busy, SW'(e_sc), SW'(e_fc)});
         end
         model_commit();
      end
   endtask

   initial begin
      test_reset();
      test_forwarding();
      test_branch_fwd();
      test_load_use();
      test_mdu();
      test_reset_mid_busy();
      test_stats();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule : tb_hazard_ctrl_unit

// File: doc/hazard_ctrl_unit.md
# hazard_ctrl_unit

Parametrised hazard and forwarding controller for the 5-stage MIPS pipeline; a superset of the current forwarding logic. Generates ALU and branch-comparator forwarding selects, detects load-use and branch-dependency hazards, and sequences a multi-cycle stall while a multiply/divide unit (MDU) op occupies EX. Sits beside the datapath and drives the stall and flush inputs of the IF/ID, ID/EX and EX/MEM pipeline registers.

## Interface
- REG_ADDR_W, 5, register address width
- MDU_LAT, 4, MDU latency in cycles; must be ≥ 2 (elaboration error otherwise)
- STAT_W, 16, statistics counter width
- i_clk  in  1  pipeline clock
- i_rst_n  in  1  asynchronous active-low reset; one clock
- i_instr_rs_D, i_instr_rt_D  in  REG_ADDR_W  source registers in ID
- i_instr_rs_E, i_instr_rt_E  in  REG_ADDR_W  source registers in EX
- i_write_reg_E, i_write_reg_M, i_write_reg_W  in  REG_ADDR_W  destination register (post RegDst mux) per stage
- i_reg_write_E, i_reg_write_M, i_reg_write_W  in  1  RegWrite per stage
- i_mem_to_reg_E, i_mem_to_reg_M  in  1  load in EX / MEM
- i_branch_D  in  1  branch/compare instruction in ID
- i_mdu_op_E  in  1  MDU instruction in EX
- o_forward_a, o_forward_b  out  2  ALU operand select: 00 regfile, 01 WB, 10 MEM
- o_forward_eq_a, o_forward_eq_b  out  1  comparator operand from MEM
- o_stall_F, o_stall_D, o_stall_E  out  1  hold PC / IF-ID / ID-EX
- o_flush_E, o_flush_M  out  1  insert bubble into ID-EX / EX-MEM
- o_mdu_busy  out  1  MDU sequencing active (registered)
- o_stall_cycles, o_flush_cycles  out  STAT_W  statistics (see Configuration)

## Operation
- Forwarding A/B: MEM match (reg_write_M, write_reg_M ≠ 0, equal to rs_E/rt_E) → 10; else the WB match → 01; else 00. MEM wins when both match.
- Comparator: o_forward_eq_a and o_forward_eq_b are evaluated independently (rs_D/rt_D vs write_reg_M, reg_write_M, ≠ 0); both may be 1 at once.
- Load-use: mem_to_reg_E & reg_write_E & write_reg_E ≠ 0 & (equal to rs_D or rt_D) → stall_F, stall_D, flush_E.
- Branch hazard: branch_D & ((reg_write_E & write_reg_E ≠ 0 & equals rs_D/rt_D) or (mem_to_reg_M & write_reg_M ≠ 0 & equals rs_D/rt_D)) → stall_F, stall_D, flush_E.
- MDU FSM states IDLE, BUSY, DONE.
  - IDLE→BUSY when i_mdu_op_E; counter loads MDU_LAT−1.
  - BUSY: counter decrements; at counter 0 goes to DONE.
  - DONE→IDLE unconditionally; i_mdu_op_E is ignored in DONE, so the same op cannot retrigger.
- While the FSM is in the IDLE cycle that detects i_mdu_op_E, or in BUSY, the block asserts stall_F, stall_D, stall_E and flush_M.
  - flush_E is forced to 0 here because EX is held; this overrides load-use and branch flush.
  - In DONE, stall_E and flush_M are deasserted, so the op advances.
- An MDU op arriving in EX on the cycle immediately after DONE starts a new sequence.

## Timing
- Forwarding, stall and flush outputs are combinational from inputs and the registered state.
- o_mdu_busy = (state ≠ IDLE), registered.
- An MDU op stalls EX for exactly MDU_LAT cycles: the detect cycle plus MDU_LAT−1 BUSY cycles. It leaves EX in the following DONE cycle.
- Reset (asynchronous, any time including mid-BUSY): state IDLE, counter 0, o_mdu_busy 0, statistics 0. With IDLE state, stall and flush outputs follow the combinational rules and are 0 when the inputs carry no hazard.

## Configuration
- HAZARD_CTRL_STATS_EN defined:
  - o_stall_cycles counts cycles with o_stall_D=1.
  - o_flush_cycles counts cycles with o_flush_E or o_flush_M = 1.
  - Both counters saturate at 2^STAT_W−1 and clear on reset.
- HAZARD_CTRL_STATS_EN undefined: ports remain present, tied to 0, and no counter flops exist.

## Structure
- hazard_pkg holds:
  - forward select constants FWD_REG=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10
  - MDU FSM state encoding IDLE/BUSY/DONE
- Sub-module mdu_stall_fsm holds the state register and latency counter.
  - Inputs: i_clk, i_rst_n, i_mdu_op_E.
  - Outputs: hold request and o_mdu_busy.
- Forwarding and hazard detection stay combinational in the top level.

## Test plan
- rs_E=3, write_reg_M=3, write_reg_W=3, both reg_write=1 → o_forward_a=10; drop reg_write_M → 01; set rs_E=0 → 00.
- Branch in ID with rs_D=4, rt_D=5; write_reg_M=4 then 5 (two cases), each with reg_write_M=1 → o_forward_eq_a=1 and o_forward_eq_b=1 respectively. Next, with write_reg_M=4 and rt_D also 4 → both outputs 1.
- Load to r7 in EX, rt_D=7 → stall_F=stall_D=flush_E=1 for one cycle; with write_reg_E=0 → no stall.
- MDU_LAT=4: pulse i_mdu_op_E and hold it high → stall_E=1 and flush_M=1 for 4 cycles, o_mdu_busy high from the 2nd through 5th cycle, no retrigger in DONE. A concurrent load-use yields flush_E=0.
- Assert i_rst_n=0 mid-BUSY → o_mdu_busy and stalls drop immediately. After release, a new op yields the full 4-cycle stall.
- With HAZARD_CTRL_STATS_EN and STAT_W=2: 5 stall cycles → o_stall_cycles saturates at 3. Without the macro → outputs constant 0.
